// File: rtl/vx_alu_writeback_if.sv
// Bus bundles for the ALU writeback block: the commit channel from execute
// and the register-file write channel toward the write arbiter.

interface vx_commit_if #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int UUID_BITS   = 44
);
    logic                      valid;
    logic                      ready;
    logic [UUID_BITS-1:0]      uuid;
    logic [NW_BITS-1:0]        wid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [31:0]               pc;
    logic [NR_BITS-1:0]        rd;
    logic                      wb;
    logic                      eop;
    logic [NUM_THREADS*32-1:0] data;

    modport master (output valid, uuid, wid, tmask, pc, rd, wb, eop, data, input ready);
    modport slave  (input valid, uuid, wid, tmask, pc, rd, wb, eop, data, output ready);
endinterface

interface vx_wb_if #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
);
    logic                      valid;
    logic                      ready;
    logic [NW_BITS-1:0]        wid;
    logic [NR_BITS-1:0]        rd;
    logic [NUM_THREADS-1:0]    tmask;
    logic [NUM_THREADS*32-1:0] data;

    modport master (output valid, wid, rd, tmask, data, input ready);
    modport slave  (input valid, wid, rd, tmask, data, output ready);
endinterface

// File: rtl/vx_alu_writeback.sv
// ALU commit receiver: in-order FIFO feeding the register-file write port,
// with registered scoreboard-release and retire pulses. Define ALU_WB_PERF_EN for perf counters.

module vx_alu_writeback #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int UUID_BITS   = 44,
    parameter int DEPTH       = 2,
    localparam int CNT_W      = $clog2(NUM_THREADS) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    vx_commit_if.slave         commit,
    vx_wb_if.master            rf_wr,
    output logic               release_valid,
    output logic [NW_BITS-1:0] release_wid,
    output logic [NR_BITS-1:0] release_rd,
    output logic               retire_valid,
    output logic [NW_BITS-1:0] retire_wid,
    output logic [CNT_W-1:0]   retire_count,
    output logic [63:0]        perf_commits,
    output logic [63:0]        perf_stalls
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef struct packed {
        logic [NW_BITS-1:0]        wid;
        logic [NR_BITS-1:0]        rd;
        logic [NUM_THREADS-1:0]    tmask;
        logic                      wb;
        logic                      eop;
        logic [NUM_THREADS*32-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    entry_t           incoming;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head_eff_wb;
    logic [CNT_W-1:0] head_count;

    // Trace id and PC are carried on the bus for debug only; nothing downstream needs them.
    logic unused_trace;
    assign unused_trace = &{1'b0, commit.uuid, commit.pc};

    // Wrap bit differs with equal index bits when the buffer is full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign commit.ready = !full;
    assign push         = commit.valid && !full;

    assign incoming = '{
        wid:   commit.wid,
        rd:    commit.rd,
        tmask: commit.tmask,
        wb:    commit.wb,
        eop:   commit.eop,
        data:  commit.data
    };

    assign head        = mem[rd_ptr[AW-1:0]];
    assign head_eff_wb = head.wb && (head.rd != '0);

    // Heads that need no register write drain on their own; others wait for the arbiter.
    assign pop = !empty && (!head_eff_wb || rf_wr.ready);

    assign rf_wr.valid = !empty && head_eff_wb;
    assign rf_wr.wid   = head.wid;
    assign rf_wr.rd    = head.rd;
    assign rf_wr.tmask = head.tmask;
    assign rf_wr.data  = head.data;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        head_count = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            head_count = head_count + CNT_W'(head.tmask[i]);
        end
    end

    // NOTE: payload storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= incoming;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Release covers x0 writes too, so the scoreboard entry the issue side set is always freed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            release_valid <= 1'b0;
            release_wid   <= '0;
            release_rd    <= '0;
            retire_valid  <= 1'b0;
            retire_wid    <= '0;
            retire_count  <= '0;
        end else begin
            release_valid <= pop && head.wb;
            retire_valid  <= pop && head.eop;
            if (pop) begin
                release_wid  <= head.wid;
                release_rd   <= head.rd;
                retire_wid   <= head.wid;
                retire_count <= head_count;
            end
        end
    end

`ifdef ALU_WB_PERF_EN
    logic [63:0] commits_q;
    logic [63:0] stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commits_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (push) begin
                commits_q <= commits_q + 64'd1;
            end
            if (rf_wr.valid && !rf_wr.ready) begin
                stalls_q <= stalls_q + 64'd1;
            end
        end
    end

    assign perf_commits = commits_q;
    assign perf_stalls  = stalls_q;
`else
    assign perf_commits = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_vx_alu_writeback.sv
// Self-checking bench for vx_alu_writeback: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.

module tb_vx_alu_writeback;

    localparam int NT    = 4;
    localparam int NWB   = 2;
    localparam int NRB   = 5;
    localparam int UB    = 44;
    localparam int DEPTH = 2;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vx_commit_if #(.NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB), .UUID_BITS(UB)) cif ();
    vx_wb_if     #(.NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB))                 wif ();

    logic           rel_v;
    logic [NWB-1:0] rel_wid;
    logic [NRB-1:0] rel_rd;
    logic           ret_v;
    logic [NWB-1:0] ret_wid;
    logic [CW-1:0]  ret_cnt;
    logic [63:0]    perf_commits;
    logic [63:0]    perf_stalls;

    vx_alu_writeback #(
        .NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB), .UUID_BITS(UB), .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (rst_n),
        .commit        (cif),
        .rf_wr         (wif),
        .release_valid (rel_v),
        .release_wid   (rel_wid),
        .release_rd    (rel_rd),
        .retire_valid  (ret_v),
        .retire_wid    (ret_wid),
        .retire_count  (ret_cnt),
        .perf_commits  (perf_commits),
        .perf_stalls   (perf_stalls)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [127:0] lanes(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [NWB-1:0] wid;
        logic [NRB-1:0] rd;
        logic [NT-1:0]  tmask;
        logic           wb;
        logic           eop;
        logic [127:0]   data;
    } ent_t;

    ent_t           q[$];
    ent_t           h;
    ent_t           nxt;
    logic           m_full;
    logic           m_eff;
    logic           m_rel_v = 1'b0;
    logic [NWB-1:0] m_rel_wid = '0;
    logic [NRB-1:0] m_rel_rd = '0;
    logic           m_ret_v = 1'b0;
    logic [NWB-1:0] m_ret_wid = '0;
    logic [CW-1:0]  m_ret_cnt = '0;
    logic [63:0]    m_commits = '0;
    logic [63:0]    m_stalls = '0;
    logic           cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_rel_v   = 1'b0;
            m_ret_v   = 1'b0;
            m_commits = '0;
            m_stalls  = '0;
        end else begin
            m_full  = (q.size() >= DEPTH);
            m_rel_v = 1'b0;
            m_ret_v = 1'b0;
            if (q.size() > 0) begin
                h     = q[0];
                m_eff = h.wb && (h.rd != 0);
                if (m_eff && !wif.ready) m_stalls = m_stalls + 64'd1;
                if (!m_eff || wif.ready) begin
                    void'(q.pop_front());
                    m_rel_v   = h.wb;
                    m_rel_wid = h.wid;
                    m_rel_rd  = h.rd;
                    m_ret_v   = h.eop;
                    m_ret_wid = h.wid;
                    m_ret_cnt = CW'($countones(h.tmask));
                end
            end
            if (cif.valid && !m_full) begin
                nxt.wid   = cif.wid;
                nxt.rd    = cif.rd;
                nxt.tmask = cif.tmask;
                nxt.wb    = cif.wb;
                nxt.eop   = cif.eop;
                nxt.data  = cif.data;
                q.push_back(nxt);
                m_commits = m_commits + 64'd1;
            end
        end
    end

    logic        e_wbv;
    logic [63:0] e_pc;
    logic [63:0] e_ps;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_ready", 128'(cif.ready), 128'(q.size() < DEPTH));
            e_wbv = 1'b0;
            if (q.size() > 0) e_wbv = q[0].wb && (q[0].rd != 0);
            check("m_wb_valid", 128'(wif.valid), 128'(e_wbv));
            if (e_wbv) begin
                check("m_wb_wid", 128'(wif.wid), 128'(q[0].wid));
                check("m_wb_rd", 128'(wif.rd), 128'(q[0].rd));
                check("m_wb_tmask", 128'(wif.tmask), 128'(q[0].tmask));
                check("m_wb_data", wif.data, q[0].data);
            end
            check("m_rel_valid", 128'(rel_v), 128'(m_rel_v));
            if (m_rel_v) begin
                check("m_rel_wid", 128'(rel_wid), 128'(m_rel_wid));
                check("m_rel_rd", 128'(rel_rd), 128'(m_rel_rd));
            end
            check("m_ret_valid", 128'(ret_v), 128'(m_ret_v));
            if (m_ret_v) begin
                check("m_ret_wid", 128'(ret_wid), 128'(m_ret_wid));
                check("m_ret_cnt", 128'(ret_cnt), 128'(m_ret_cnt));
            end
`ifdef ALU_WB_PERF_EN
            e_pc = m_commits;
            e_ps = m_stalls;
`else
            e_pc = '0;
            e_ps = '0;
`endif
            check("m_perf_commits", 128'(perf_commits), 128'(e_pc));
            check("m_perf_stalls", 128'(perf_stalls), 128'(e_ps));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_fields(input logic [NWB-1:0] wid, input logic [NRB-1:0] rd,
                              input logic wb, input logic eop, input logic [NT-1:0] tmask,
                              input logic [127:0] data);
        cif.uuid  = UB'($urandom);
        cif.pc    = 32'h8000_0000 + 32'(rd) * 4;
        cif.wid   = wid;
        cif.rd    = rd;
        cif.wb    = wb;
        cif.eop   = eop;
        cif.tmask = tmask;
        cif.data  = data;
    endtask

    task automatic send(input logic [NWB-1:0] wid, input logic [NRB-1:0] rd,
                        input logic wb, input logic eop, input logic [NT-1:0] tmask,
                        input logic [127:0] data);
        set_fields(wid, rd, wb, eop, tmask, data);
        cif.valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cif.ready) begin
                @(posedge clk);
                #1;
                cif.valid = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL send_timeout: commit_ready never rose for rd %0d", rd);
        cif.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cif.valid = 1'b0;
        wif.ready = 1'b1;
        set_fields('0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_ready", 128'(cif.ready), 128'(1));
        check("rst_wb_valid", 128'(wif.valid), 128'(0));
        check("rst_rel_valid", 128'(rel_v), 128'(0));
        check("rst_ret_valid", 128'(ret_v), 128'(0));
        rst_n = 1'b1;
        idle(2);

        // single commit
        send(2'd1, 5'd5, 1'b1, 1'b1, 4'b1011, lanes(32'd1, 32'd2, 32'd3, 32'd4));
        @(negedge clk);
        check("single_wb_valid", 128'(wif.valid), 128'(1));
        check("single_wb_wid", 128'(wif.wid), 128'(1));
        check("single_wb_rd", 128'(wif.rd), 128'(5));
        check("single_wb_tmask", 128'(wif.tmask), 128'(4'b1011));
        check("single_wb_data", wif.data, {32'd4, 32'd3, 32'd2, 32'd1});
        @(negedge clk);
        check("single_wb_done", 128'(wif.valid), 128'(0));
        check("single_rel", 128'({rel_v, rel_wid, rel_rd}), 128'({1'b1, 2'd1, 5'd5}));
        check("single_ret", 128'({ret_v, ret_wid, ret_cnt}), 128'({1'b1, 2'd1, 3'd3}));
        idle(2);

        // backpressure: three offers, two fit
        wif.ready = 1'b0;
        set_fields(2'd0, 5'd1, 1'b1, 1'b1, 4'b0001, lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        cif.valid = 1'b1;
        @(posedge clk); #1;
        set_fields(2'd1, 5'd2, 1'b1, 1'b1, 4'b0011, lanes(32'hB0, 32'hB1, 32'hB2, 32'hB3));
        @(posedge clk); #1;
        set_fields(2'd2, 5'd3, 1'b1, 1'b1, 4'b0111, lanes(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        @(negedge clk);
        check("bp_full_ready", 128'(cif.ready), 128'(0));
        check("bp_head_rd", 128'(wif.rd), 128'(1));
        @(negedge clk);
        check("bp_still_full", 128'(cif.ready), 128'(0));
        check("bp_stable_rd", 128'(wif.rd), 128'(1));
        check("bp_stable_data", wif.data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        wif.ready = 1'b1;
        @(negedge clk);
        check("bp_second_rd", 128'(wif.rd), 128'(2));
        check("bp_ready_back", 128'(cif.ready), 128'(1));
        @(posedge clk); #1;
        cif.valid = 1'b0;
        @(negedge clk);
        check("bp_third_rd", 128'(wif.rd), 128'(3));
        idle(3);

        // no write-back
        send(2'd3, 5'd9, 1'b0, 1'b1, 4'b1111, lanes(32'd7, 32'd7, 32'd7, 32'd7));
        @(negedge clk);
        check("nowb_wb_valid", 128'(wif.valid), 128'(0));
        @(negedge clk);
        check("nowb_rel_valid", 128'(rel_v), 128'(0));
        check("nowb_ret", 128'({ret_v, ret_wid, ret_cnt}), 128'({1'b1, 2'd3, 3'd4}));
        idle(2);

        // x0 destination
        send(2'd2, 5'd0, 1'b1, 1'b1, 4'b0001, lanes(32'd9, 32'd0, 32'd0, 32'd0));
        @(negedge clk);
        check("x0_wb_valid", 128'(wif.valid), 128'(0));
        @(negedge clk);
        check("x0_rel", 128'({rel_v, rel_wid, rel_rd}), 128'({1'b1, 2'd2, 5'd0}));
        check("x0_ret", 128'({ret_v, ret_wid, ret_cnt}), 128'({1'b1, 2'd2, 3'd1}));
        idle(2);

        // empty tmask, not end of packet
        send(2'd1, 5'd7, 1'b1, 1'b0, 4'b0000, lanes(32'd5, 32'd6, 32'd7, 32'd8));
        @(negedge clk);
        check("tm0_wb_valid", 128'(wif.valid), 128'(1));
        check("tm0_wb_tmask", 128'(wif.tmask), 128'(0));
        @(negedge clk);
        check("tm0_rel", 128'({rel_v, rel_rd}), 128'({1'b1, 5'd7}));
        check("tm0_no_retire", 128'(ret_v), 128'(0));
        idle(2);

        // streaming eight commits
        cif.valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_fields(NWB'(i), NRB'(i + 8), 1'b1, 1'b1, NT'(i + 1),
                       lanes(32'(i), 32'(i * 3), 32'(i * 5), 32'(i * 7)));
            @(negedge clk);
            check("stream_ready", 128'(cif.ready), 128'(1));
            if (i > 0) check("stream_rd", 128'({wif.valid, wif.rd}), 128'({1'b1, NRB'(i + 7)}));
            @(posedge clk); #1;
        end
        cif.valid = 1'b0;
        @(negedge clk);
        check("stream_last_rd", 128'({wif.valid, wif.rd}), 128'({1'b1, 5'd15}));
        idle(3);

        // asynchronous reset with two entries held
        wif.ready = 1'b0;
        set_fields(2'd0, 5'd20, 1'b1, 1'b1, 4'b1111, lanes(32'h20, 32'h21, 32'h22, 32'h23));
        cif.valid = 1'b1;
        @(posedge clk); #1;
        set_fields(2'd1, 5'd21, 1'b1, 1'b1, 4'b1111, lanes(32'h30, 32'h31, 32'h32, 32'h33));
        @(posedge clk); #1;
        cif.valid = 1'b0;
        @(negedge clk);
        check("ar_held_valid", 128'(wif.valid), 128'(1));
        check("ar_held_full", 128'(cif.ready), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_wb_valid", 128'(wif.valid), 128'(0));
        check("ar_ready", 128'(cif.ready), 128'(1));
        check("ar_rel_ret", 128'({rel_v, ret_v}), 128'(0));
        check("ar_perf_commits", 128'(perf_commits), 128'(0));
        wif.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar_no_ghost_write", 128'({wif.valid, rel_v, ret_v}), 128'(0));
        end
        check("ar_perf_commits_after", 128'(perf_commits), 128'(0));
        check("ar_perf_stalls_after", 128'(perf_stalls), 128'(0));

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
